// File: rtl/corr_scan_ctrl_pkg.sv
// Shared definitions for the correlation scan controller.
// Holds the FSM state encoding, coordinate/score widths, the default
// per-position timeout, the window payload struct and the step-fit helper.
package corr_scan_ctrl_pkg;

    localparam int unsigned COORD_W         = 13;
    localparam int unsigned COORD_EXT_W     = COORD_W + 1;
    localparam int unsigned SCORE_W         = 16;
    localparam int unsigned WAIT_W          = 16;
    localparam int unsigned COUNT_W         = 16;
    localparam int unsigned TMO_W           = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 4095;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ARM   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_EVAL  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Inclusive scan window bounds
    typedef struct packed {
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
    } win_t;

    // Best candidate found so far
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SCORE_W-1:0] score;
    } best_t;

    // True when pos+step stays within lim; one extra bit so the top of the range never wraps
    function automatic logic step_fits(
        input logic [COORD_W-1:0] pos,
        input logic [COORD_W-1:0] step,
        input logic [COORD_W-1:0] lim
    );
        return (COORD_EXT_W'(pos) + COORD_EXT_W'(step)) <= COORD_EXT_W'(lim);
    endfunction

endpackage

// File: rtl/corr_pos_gen.sv
// Raster position generator for the correlation scan (X inner, Y outer).
// Ports:
//   i_clk, i_rst_n  clock / async active-low reset
//   i_init          load position with (xmin, ymin)
//   i_step          advance one raster position (held when already last)
//   i_win           inclusive window bounds
//   o_pos_x/o_pos_y current candidate position (registered)
//   o_last_c        current position is the final one of the window
module corr_pos_gen
    import corr_scan_ctrl_pkg::*;
#(
    parameter int unsigned XSTEP = 1,
    parameter int unsigned YSTEP = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_init,
    input  logic               i_step,
    input  win_t               i_win,
    output logic [COORD_W-1:0] o_pos_x,
    output logic [COORD_W-1:0] o_pos_y,
    output logic               o_last_c
);

    localparam logic [COORD_W-1:0] XSTEP_C = COORD_W'(XSTEP);
    localparam logic [COORD_W-1:0] YSTEP_C = COORD_W'(YSTEP);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               w_x_fits;
    logic               w_y_fits;

    assign w_x_fits = step_fits(r_x, XSTEP_C, i_win.xmax);
    assign w_y_fits = step_fits(r_y, YSTEP_C, i_win.ymax);
    assign o_last_c = !w_x_fits && !w_y_fits;

    assign o_pos_x = r_x;
    assign o_pos_y = r_y;

    // Position register; stepping past the last position is suppressed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_init) begin
            r_x <= i_win.xmin;
            r_y <= i_win.ymin;
        end else if (i_step) begin
            if (w_x_fits) begin
                r_x <= r_x + XSTEP_C;
            end else if (w_y_fits) begin
                r_x <= i_win.xmin;
                r_y <= r_y + YSTEP_C;
            end
        end
    end

endmodule

// File: rtl/corr_scan_ctrl.sv
// Correlation scan controller: walks a window of candidate positions,
// restarts the correlation engine at each one, and keeps the best score.
// Ports:
//   iCLK, iRST_N                     clock / async active-low reset
//   iStart, iXmin..iYmax             scan request and inclusive window
//   oEng_start, oXstart, oYstart     engine restart pulse and candidate position
//   iEng_finished, iEng_score        engine completion flag and result
//   oBusy, oDone, oBadWin            status (oDone is a one-cycle pulse)
//   oTimeouts, oCount                abandoned / evaluated position counts
//   oBestX, oBestY, oBestScore       best candidate found
module corr_scan_ctrl
    import corr_scan_ctrl_pkg::*;
#(
    parameter int unsigned XSTEP   = 1,
    parameter int unsigned YSTEP   = 1,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iStart,
    input  logic [COORD_W-1:0] iXmin,
    input  logic [COORD_W-1:0] iXmax,
    input  logic [COORD_W-1:0] iYmin,
    input  logic [COORD_W-1:0] iYmax,
    output logic               oEng_start,
    output logic [COORD_W-1:0] oXstart,
    output logic [COORD_W-1:0] oYstart,
    input  logic               iEng_finished,
    input  logic [SCORE_W-1:0] iEng_score,
    output logic               oBusy,
    output logic               oDone,
    output logic               oBadWin,
    output logic [TMO_W-1:0]   oTimeouts,
    output logic [COUNT_W-1:0] oCount,
    output logic [COORD_W-1:0] oBestX,
    output logic [COORD_W-1:0] oBestY,
    output logic [SCORE_W-1:0] oBestScore
);

    // Last wait-counter value before the position is abandoned
    localparam logic [WAIT_W-1:0] TO_LAST =
        WAIT_W'((TIMEOUT > 32'd0) ? (TIMEOUT - 32'd1) : 32'd0);

    state_t               r_state;
    state_t               w_next_state;
    win_t                 r_win;
    best_t                r_best;
    logic [COUNT_W-1:0]   r_count;
    logic [TMO_W-1:0]     r_timeouts;
    logic                 r_bad_win;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic                 r_timed_out;
    logic                 r_eng_start;
    logic                 r_done;
    logic                 r_busy;

    logic [COORD_W-1:0]   w_pos_x;
    logic [COORD_W-1:0]   w_pos_y;
    logic                 w_last;
    logic                 w_bad_win;
    logic                 w_to_hit;

    logic                 w_latch;
    logic                 w_init;
    logic                 w_bad;
    logic                 w_wait_clr;
    logic                 w_wait_inc;
    logic                 w_eval_enter;
    logic                 w_eval_to;
    logic                 w_eval;
    logic                 w_step;

    assign w_bad_win = (r_win.xmax < r_win.xmin) || (r_win.ymax < r_win.ymin);
    assign w_to_hit  = (r_wait_cnt >= TO_LAST);

    corr_pos_gen #(
        .XSTEP (XSTEP),
        .YSTEP (YSTEP)
    ) u_pos_gen (
        .i_clk    (iCLK),
        .i_rst_n  (iRST_N),
        .i_init   (w_init),
        .i_step   (w_step),
        .i_win    (r_win),
        .o_pos_x  (w_pos_x),
        .o_pos_y  (w_pos_y),
        .o_last_c (w_last)
    );

    // State register
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; ARM holds until a stale finished flag drops
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (iStart) w_next_state = ST_CHECK;
            ST_CHECK: w_next_state = w_bad_win ? ST_DONE : ST_LOAD;
            ST_LOAD:  w_next_state = ST_ARM;
            ST_ARM: begin
                if (w_to_hit) begin
                    w_next_state = ST_EVAL;
                end else if (!iEng_finished) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT:  if (iEng_finished || w_to_hit) w_next_state = ST_EVAL;
            ST_EVAL:  w_next_state = w_last ? ST_DONE : ST_LOAD;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Per-state datapath controls; a real finish wins over a same-cycle timeout
    always_comb begin
        w_latch      = 1'b0;
        w_init       = 1'b0;
        w_bad        = 1'b0;
        w_wait_clr   = 1'b0;
        w_wait_inc   = 1'b0;
        w_eval_enter = 1'b0;
        w_eval_to    = 1'b0;
        w_eval       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            ST_IDLE:  w_latch = iStart;
            ST_CHECK: begin
                w_bad  = w_bad_win;
                w_init = !w_bad_win;
            end
            ST_LOAD:  w_wait_clr = 1'b1;
            ST_ARM: begin
                w_eval_enter = w_to_hit;
                w_eval_to    = w_to_hit;
                w_wait_inc   = !w_to_hit;
            end
            ST_WAIT: begin
                w_eval_enter = iEng_finished || w_to_hit;
                w_eval_to    = !iEng_finished && w_to_hit;
                w_wait_inc   = !(iEng_finished || w_to_hit);
            end
            ST_EVAL: begin
                w_eval = 1'b1;
                w_step = !w_last;
            end
            default: ;
        endcase
    end

    // Window latch, wait counter, best tracking and statistics
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_win       <= '0;
            r_best      <= '0;
            r_count     <= '0;
            r_timeouts  <= '0;
            r_bad_win   <= 1'b0;
            r_wait_cnt  <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if (w_latch) begin
                r_win.xmin <= iXmin;
                r_win.xmax <= iXmax;
                r_win.ymin <= iYmin;
                r_win.ymax <= iYmax;
                r_bad_win  <= 1'b0;
            end
            if (w_bad) begin
                r_bad_win <= 1'b1;
                r_count   <= '0;
            end
            if (w_init) begin
                r_best     <= '0;
                r_count    <= '0;
                r_timeouts <= '0;
            end
            if (w_wait_clr) begin
                r_wait_cnt <= '0;
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_eval_enter) begin
                r_timed_out <= w_eval_to;
            end
            if (w_eval) begin
                if (!r_timed_out) begin
                    // Strict compare: ties keep the earlier raster position
                    if ((r_count == '0) || (iEng_score > r_best.score)) begin
                        r_best.x     <= w_pos_x;
                        r_best.y     <= w_pos_y;
                        r_best.score <= iEng_score;
                    end
                end else if (r_timeouts != '1) begin
                    r_timeouts <= r_timeouts + TMO_W'(1);
                end
                if (r_count != '1) begin
                    r_count <= r_count + COUNT_W'(1);
                end
            end
        end
    end

    // Registered status strobes aligned with the state they describe
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_eng_start <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_eng_start <= (w_next_state == ST_LOAD);
            r_done      <= (w_next_state == ST_DONE);
            r_busy      <= (w_next_state != ST_IDLE);
        end
    end

    assign oEng_start = r_eng_start;
    assign oXstart    = w_pos_x;
    assign oYstart    = w_pos_y;
    assign oBusy      = r_busy;
    assign oDone      = r_done;
    assign oBadWin    = r_bad_win;
    assign oTimeouts  = r_timeouts;
    assign oCount     = r_count;
    assign oBestX     = r_best.x;
    assign oBestY     = r_best.y;
    assign oBestScore = r_best.score;

endmodule

// File: tb/tb_corr_scan_ctrl.sv
// Directed bench for corr_scan_ctrl with a behavioural correlation engine.
`timescale 1ns/1ps
module tb_corr_scan_ctrl;

    localparam int LAT     = 3;
    localparam int BUDGET  = 2000;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iStart = 1'b0;
    logic [12:0] iXmin = '0, iXmax = '0, iYmin = '0, iYmax = '0;
    logic        oEng_start;
    logic [12:0] oXstart, oYstart;
    logic        iEng_finished = 1'b0;
    logic [15:0] iEng_score = '0;
    logic        oBusy, oDone, oBadWin;
    logic [7:0]  oTimeouts;
    logic [15:0] oCount;
    logic [12:0] oBestX, oBestY;
    logic [15:0] oBestScore;

    int n_checks = 0;
    int n_fail   = 0;
    int n_loads  = 0;
    int n_done   = 0;
    int cyc      = 0;
    int last_start = 0;
    int gap_q[$];

    bit          score_flat = 1'b0;
    bit          stale_mode = 1'b0;
    int          stale_n    = 0;
    bit          hang_en    = 1'b0;
    logic [12:0] hang_x = '0, hang_y = '0;

    int          lat_cnt = 0;
    int          stale_cnt = 0;
    bit          hang = 1'b0;
    logic [12:0] cur_x = '0, cur_y = '0;

    corr_scan_ctrl #(.XSTEP(1), .YSTEP(1), .TIMEOUT(10)) dut (
        .iCLK          (iCLK),
        .iRST_N        (iRST_N),
        .iStart        (iStart),
        .iXmin         (iXmin),
        .iXmax         (iXmax),
        .iYmin         (iYmin),
        .iYmax         (iYmax),
        .oEng_start    (oEng_start),
        .oXstart       (oXstart),
        .oYstart       (oYstart),
        .iEng_finished (iEng_finished),
        .iEng_score    (iEng_score),
        .oBusy         (oBusy),
        .oDone         (oDone),
        .oBadWin       (oBadWin),
        .oTimeouts     (oTimeouts),
        .oCount        (oCount),
        .oBestX        (oBestX),
        .oBestY        (oBestY),
        .oBestScore    (oBestScore)
    );

    always #5 iCLK = ~iCLK;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Score map: hand table for the 3x2 corner, x+2y elsewhere
    function automatic logic [15:0] score_of(input logic [12:0] x, input logic [12:0] y);
        if (score_flat) return 16'd500;
        if (y == 13'd0) begin
            if (x == 13'd0) return 16'd100;
            if (x == 13'd1) return 16'd300;
            if (x == 13'd2) return 16'd200;
        end else if (y == 13'd1) begin
            if (x == 13'd0) return 16'd400;
            if (x == 13'd1) return 16'd500;
            if (x == 13'd2) return 16'd900;
        end
        return 16'(x) + 16'(y) * 16'd2;
    endfunction

    // Engine model: finished is held until the next restart pulse
    always @(negedge iCLK) begin
        cyc++;
        if (oDone) n_done++;
        if (!iRST_N) begin
            lat_cnt   = 0;
            stale_cnt = 0;
        end else if (oEng_start) begin
            n_loads++;
            gap_q.push_back(cyc - last_start);
            last_start = cyc;
            cur_x   = oXstart;
            cur_y   = oYstart;
            hang    = hang_en && (oXstart == hang_x) && (oYstart == hang_y);
            lat_cnt = LAT;
            if (stale_mode) begin
                stale_cnt     = stale_n;
                iEng_finished = 1'b1;
                iEng_score    = 16'd60000;
            end else begin
                iEng_finished = 1'b0;
            end
        end else if (stale_cnt > 0) begin
            stale_cnt--;
            if (stale_cnt == 0) iEng_finished = 1'b0;
        end else if (lat_cnt > 0) begin
            lat_cnt--;
            if (lat_cnt == 0 && !hang) begin
                check_eq("pos_stable", {oXstart, oYstart}, {cur_x, cur_y});
                iEng_finished = 1'b1;
                iEng_score    = score_of(cur_x, cur_y);
            end
        end
    end

    task automatic run_scan(input logic [12:0] xmin, input logic [12:0] xmax,
                            input logic [12:0] ymin, input logic [12:0] ymax,
                            output int waited);
        @(negedge iCLK);
        iXmin = xmin; iXmax = xmax; iYmin = ymin; iYmax = ymax;
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        waited = 0;
        while (!oDone && waited < BUDGET) begin
            @(negedge iCLK);
            waited++;
        end
        check_eq("done_seen", oDone, 1);
        @(negedge iCLK);
        @(negedge iCLK);
    endtask

    task automatic clear_stats();
        @(negedge iCLK);
        n_loads = 0;
        n_done  = 0;
        gap_q.delete();
    endtask

    task automatic check_result(input string tag, input int loads, input int cnt,
                                input int bx, input int by, input int bs, input int tmo);
        check_eq({tag, "_loads"}, n_loads, loads);
        check_eq({tag, "_count"}, oCount, cnt);
        check_eq({tag, "_bestx"}, oBestX, bx);
        check_eq({tag, "_besty"}, oBestY, by);
        check_eq({tag, "_score"}, oBestScore, bs);
        check_eq({tag, "_tmo"}, oTimeouts, tmo);
        check_eq({tag, "_dones"}, n_done, 1);
        check_eq({tag, "_badwin"}, oBadWin, 0);
        check_eq({tag, "_busy"}, oBusy, 0);
    endtask

    initial begin
        int w;
        int k;
        int snap_done;

        // Reset state
        repeat (3) @(negedge iCLK);
        check_eq("rst_busy", oBusy, 0);
        check_eq("rst_done", oDone, 0);
        check_eq("rst_engstart", oEng_start, 0);
        check_eq("rst_badwin", oBadWin, 0);
        check_eq("rst_count", oCount, 0);
        check_eq("rst_best", {oBestX, oBestY, oBestScore}, 0);
        check_eq("rst_pos", {oXstart, oYstart}, 0);
        iRST_N = 1'b1;
        @(negedge iCLK);
        check_eq("idle_busy", oBusy, 0);

        // Peak 900 at (2,1)
        clear_stats();
        run_scan(13'd0, 13'd2, 13'd0, 13'd1, w);
        check_result("peak", 6, 6, 2, 1, 900, 0);

        // All scores equal, with a stray iStart mid-scan that must be ignored
        clear_stats();
        score_flat = 1'b1;
        @(negedge iCLK);
        iXmin = 13'd3; iXmax = 13'd4; iYmin = 13'd5; iYmax = 13'd6;
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        k = 0;
        while (n_loads < 2 && k < BUDGET) begin @(negedge iCLK); k++; end
        iXmin = 13'd0; iXmax = 13'd0; iYmin = 13'd0; iYmax = 13'd0;
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        k = 0;
        while (!oDone && k < BUDGET) begin @(negedge iCLK); k++; end
        check_eq("tie_done_seen", oDone, 1);
        repeat (2) @(negedge iCLK);
        score_flat = 1'b0;
        check_result("tie", 4, 4, 3, 5, 500, 0);

        // Inverted X bounds
        clear_stats();
        run_scan(13'd5, 13'd3, 13'd0, 13'd0, w);
        check_eq("bad_latency_le3", (w <= 3), 1);
        check_eq("bad_badwin", oBadWin, 1);
        check_eq("bad_count", oCount, 0);
        check_eq("bad_loads", n_loads, 0);
        check_eq("bad_dones", n_done, 1);

        // Single-point window
        clear_stats();
        run_scan(13'd7, 13'd7, 13'd7, 13'd7, w);
        check_result("single", 1, 1, 7, 7, 21, 0);

        // Top of the coordinate range must not wrap
        clear_stats();
        run_scan(13'd8190, 13'd8191, 13'd8191, 13'd8191, w);
        check_result("edge", 2, 2, 8191, 8191, 24573, 0);

        // Engine hangs at (1,0): abandoned after 10 wait cycles
        clear_stats();
        hang_en = 1'b1; hang_x = 13'd1; hang_y = 13'd0;
        run_scan(13'd0, 13'd2, 13'd0, 13'd0, w);
        hang_en = 1'b0;
        check_result("tmo", 3, 3, 2, 0, 200, 1);
        if (gap_q.size() >= 3) check_eq("tmo_gap", gap_q[2], 12);
        else check_eq("tmo_gap_missing", gap_q.size(), 3);

        // Finished still high from the previous run, with a poison score
        clear_stats();
        check_eq("stale_pre_finished", iEng_finished, 1);
        stale_mode = 1'b1; stale_n = 4;
        run_scan(13'd0, 13'd1, 13'd0, 13'd0, w);
        stale_mode = 1'b0;
        check_result("stale", 2, 2, 1, 0, 300, 0);

        // Reset during WAIT of the second position
        clear_stats();
        @(negedge iCLK);
        iXmin = 13'd0; iXmax = 13'd2; iYmin = 13'd0; iYmax = 13'd1;
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        k = 0;
        w = 0;
        while (k < 2 && w < BUDGET) begin
            @(posedge iCLK); #1;
            if (oEng_start) k++;
            w++;
        end
        check_eq("mid_reach_load2", k, 2);
        repeat (2) begin @(posedge iCLK); #1; end
        snap_done = n_done;
        #3 iRST_N = 1'b0;
        #1;
        check_eq("mid_busy", oBusy, 0);
        check_eq("mid_count", oCount, 0);
        check_eq("mid_best", {oBestX, oBestY, oBestScore}, 0);
        check_eq("mid_pos", {oXstart, oYstart}, 0);
        check_eq("mid_engstart", oEng_start, 0);
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (3) @(negedge iCLK);
        check_eq("mid_no_done", n_done, snap_done);
        check_eq("mid_idle", oBusy, 0);
        clear_stats();
        run_scan(13'd0, 13'd2, 13'd0, 13'd1, w);
        check_result("post_rst", 6, 6, 2, 1, 900, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/corr_scan_ctrl.md
CORR_SCAN_CTRL -- requirements
Module: corr_scan_ctrl

Interface
REQ-001 SHALL have parameter XSTEP, default 1: X increment between candidate positions.
REQ-002 SHALL have parameter YSTEP, default 1: Y increment between candidate rows.
REQ-003 SHALL have parameter TIMEOUT, default 4095: maximum wait cycles per position before it is abandoned.
REQ-004 SHALL have ports: iCLK in 1, single clock; iRST_N in 1, reset (one clock; reset asynchronous, active-low).
REQ-005 SHALL have ports: iStart in 1, scan request pulse; iXmin, iXmax, iYmin, iYmax in 13 each, inclusive window bounds.
REQ-006 SHALL have ports: oEng_start out 1, engine restart pulse; oXstart, oYstart out 13 each, candidate position to engine; iEng_finished in 1; iEng_score in 16.
REQ-007 SHALL have ports: oBusy out 1; oDone out 1, one-cycle pulse; oBadWin out 1; oTimeouts out 8; oCount out 16.
REQ-008 SHALL have ports: oBestX, oBestY out 13 each; oBestScore out 16.

Function
REQ-009 SHALL implement states IDLE, CHECK, LOAD, ARM, WAIT, EVAL, DONE.
REQ-010 IDLE SHALL move to CHECK on iStart=1 and latch all four bounds; iStart outside IDLE SHALL be ignored.
REQ-011 CHECK SHALL go to DONE with oBadWin=1 and oCount=0 if iXmax<iXmin or iYmax<iYmin; otherwise SHALL clear best/count/timeouts, set X=Xmin, Y=Ymin, and go to LOAD.
REQ-012 LOAD SHALL drive oXstart/oYstart to the current X/Y, assert oEng_start for exactly one cycle, and go to ARM.
REQ-013 ARM SHALL wait for iEng_finished=0 (stale-flag rejection) and then go to WAIT.
REQ-014 WAIT SHALL go to EVAL on the first cycle with iEng_finished=1.
REQ-015 A 16-bit wait counter SHALL run across ARM+WAIT; on reaching TIMEOUT it SHALL go to EVAL flagged as timed out.
REQ-016 EVAL, not timed out: if oCount=0 or iEng_score>oBestScore (strict), best SHALL become {X,Y,iEng_score}; ties SHALL keep the earlier position.
REQ-017 EVAL, timed out: best SHALL be unchanged and oTimeouts SHALL increment, saturating at 255.
REQ-018 EVAL SHALL increment oCount, saturating at 65535.
REQ-019 Position advance SHALL be raster order, X inner.
REQ-020 If X+XSTEP<=Xmax, then X+=XSTEP; else X=Xmin and Y+=YSTEP; if Y+YSTEP>Ymax, go to DONE instead of LOAD.
REQ-021 Bound comparisons SHALL use 14-bit sums so that 8191+step never wraps.
REQ-022 DONE SHALL pulse oDone for one cycle, then return to IDLE; best and count SHALL hold until the next accepted iStart.
REQ-023 oBusy SHALL be 1 in every state except IDLE.
REQ-024 oXstart/oYstart SHALL stay stable from LOAD through EVAL.
REQ-025 Single-point window (min=max on both axes) SHALL produce exactly one LOAD and oCount=1.

Reset
REQ-026 iRST_N=0 SHALL asynchronously force IDLE and set all outputs and registers to 0, with oDone=0 and oEng_start=0.
REQ-027 Reset asserted mid-scan SHALL abort the scan with no oDone pulse; the first accepted iStart after release SHALL begin a fresh scan.

Structure
REQ-028 A shared package/header SHALL hold the state encoding, the 13-bit coordinate width, the 16-bit score width, and the TIMEOUT default.
REQ-029 The raster position generator SHALL be one sub-module, corr_pos_gen, with ports: init, step, pos X/Y, last.
REQ-030 Best-score tracking and FSM SHALL reside in corr_scan_ctrl.

Verification
REQ-031 Window X 0..2, Y 0..1, model scores with peak 900 at (2,1) -> 6 LOADs, oBestX=2, oBestY=1, oBestScore=900, oCount=6, one oDone.
REQ-032 Equal scores 500 at every position -> best=(Xmin,Ymin), oBestScore=500.
REQ-033 iXmax=3, iXmin=5 -> oDone within 3 cycles, oBadWin=1, no oEng_start.
REQ-034 Engine never finishes at (1,0), TIMEOUT=10 -> that position is abandoned after 10 cycles, oTimeouts=1, scan completes, best comes from the other positions.
REQ-035 iEng_finished held high from the previous run -> ARM holds until it drops; no early EVAL.
REQ-036 iRST_N pulsed low during WAIT -> immediate IDLE with outputs 0; a new iStart runs a full scan correctly.
